// File: rtl/wb_arbiter_pkg.sv
// Shared types for the Wishbone round-robin arbiter.
package wb_arbiter_pkg;

  // Bus ownership states; exposed on the arbiter's state_o debug output.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin requester search: first set request bit after 'last', wrapping
// modulo MASTERS_NUM (works for non-power-of-two counts).
module wb_rr_pick #(
  parameter int  MASTERS_NUM = 2,
  localparam int IDX_W       = $clog2(MASTERS_NUM)
) (
  input  logic [MASTERS_NUM-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic                   found,
  output logic [IDX_W-1:0]       idx
);

  // Scan last+1, last+2, ... last+MASTERS_NUM and keep the first hit.
  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    idx   = last;
    for (int k = 1; k <= MASTERS_NUM; k++) begin
      cand = (int'(last) + k) % MASTERS_NUM;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Wishbone shared-bus round-robin arbiter with a per-transfer watchdog.
// Handshake: a master requests with cyc; it owns the bus while gnt_vld_o is 1
// and releases by dropping cyc. A strobed transfer that sees neither ack nor
// err for TIMEOUT cycles is aborted with a one-cycle error on i2m_tmo_o; the
// bus stays masked (gnt_vld_o=0) until the master drops cyc.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int  MASTERS_NUM = 2,
  parameter int  TIMEOUT     = 15,
  localparam int IDX_W       = $clog2(MASTERS_NUM),
  localparam int CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [MASTERS_NUM-1:0] m2i_cyc_i,
  input  logic [MASTERS_NUM-1:0] m2i_stb_i,
  input  logic                   s2i_ack_i,
  input  logic                   s2i_err_i,
  output logic [MASTERS_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]       gnt_idx_o,
  output logic                   gnt_vld_o,
  output logic [MASTERS_NUM-1:0] i2m_tmo_o,
  output logic                   tmo_evt_o,
  output arb_state_t             state_o
);

  localparam bit         TMO_EN   = (TIMEOUT != 0);
  localparam [CNT_W-1:0] WDC_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t             state_q, state_d;
  logic [MASTERS_NUM-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   vld_q, vld_d;
  logic [MASTERS_NUM-1:0] tmo_q, tmo_d;
  logic                   evt_q, evt_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       wdc_q, wdc_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   own_cyc;
  logic                   stall;

  wb_rr_pick #(.MASTERS_NUM(MASTERS_NUM)) u_pick (
    .req   (m2i_cyc_i),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_cyc = m2i_cyc_i[idx_q];
  // A transfer is stalling when strobed and the slave gives no response.
  assign stall   = m2i_stb_i[idx_q] & ~s2i_ack_i & ~s2i_err_i;

  // Next-state and next-output logic; pulses default to zero every cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    last_d  = last_q;
    wdc_d   = wdc_q;
    tmo_d   = '0;
    evt_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        wdc_d = '0;
        if (pick_found) begin
          idx_d   = pick_idx;
          gnt_d   = MASTERS_NUM'(1) << pick_idx;
          vld_d   = 1'b1;
          state_d = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        // Release beats the watchdog.
        if (!own_cyc) begin
          last_d  = idx_q;
          gnt_d   = '0;
          vld_d   = 1'b0;
          wdc_d   = '0;
          state_d = ARB_IDLE;
        end else if (TMO_EN && stall && (wdc_q == WDC_LAST)) begin
          tmo_d   = gnt_q;
          evt_d   = 1'b1;
          vld_d   = 1'b0;
          wdc_d   = '0;
          state_d = ARB_ABORT;
        end else if (stall) begin
          wdc_d = (&wdc_q) ? wdc_q : wdc_q + CNT_W'(1);
        end else begin
          wdc_d = '0;
        end
      end
      ARB_ABORT: begin
        // Grant is held but masked; late responses are ignored.
        if (!own_cyc) begin
          last_d  = idx_q;
          gnt_d   = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        vld_d   = 1'b0;
        wdc_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs; last resets to the top index so master 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      tmo_q   <= '0;
      evt_q   <= 1'b0;
      last_q  <= IDX_W'(MASTERS_NUM - 1);
      wdc_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
      evt_q   <= evt_d;
      last_q  <= last_d;
      wdc_q   <= wdc_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign gnt_vld_o = vld_q;
  assign i2m_tmo_o = tmo_q;
  assign tmo_evt_o = evt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, every cycle
// compared against an ownership-level reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam int IW  = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // DUT (TIMEOUT=8)
  logic [N-1:0]  cyc = '0, stb = '0;
  logic          ack = 1'b0, err = 1'b0;
  logic [N-1:0]  gnt, tmo;
  logic [IW-1:0] gidx;
  logic          gvld, evt;
  arb_state_t    st;

  wb_arbiter #(.MASTERS_NUM(N), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .m2i_cyc_i(cyc), .m2i_stb_i(stb),
    .s2i_ack_i(ack), .s2i_err_i(err), .gnt_o(gnt), .gnt_idx_o(gidx),
    .gnt_vld_o(gvld), .i2m_tmo_o(tmo), .tmo_evt_o(evt), .state_o(st)
  );

  // Watchdog-disabled build
  logic [N-1:0]  z_cyc = '0, z_stb = '0;
  logic          z_ack = 1'b0, z_err = 1'b0;
  logic [N-1:0]  z_gnt, z_tmo;
  logic [IW-1:0] z_idx;
  logic          z_vld, z_evt;
  arb_state_t    z_st;

  wb_arbiter #(.MASTERS_NUM(N), .TIMEOUT(0)) dut_z (
    .clk_i(clk), .rst_i(rst), .m2i_cyc_i(z_cyc), .m2i_stb_i(z_stb),
    .s2i_ack_i(z_ack), .s2i_err_i(z_err), .gnt_o(z_gnt), .gnt_idx_o(z_idx),
    .gnt_vld_o(z_vld), .i2m_tmo_o(z_tmo), .tmo_evt_o(z_evt), .state_o(z_st)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether it was aborted, and how many
  // consecutive stalled transfer cycles the owner has seen.
  int            m_owner = -1;
  int            m_last  = N - 1;
  int            m_stall = 0;
  bit            m_abort = 1'b0;
  logic [IW-1:0] m_idx   = '0;
  logic [N-1:0]  m_tmo   = '0;
  logic          m_evt   = 1'b0;

  // Scoreboard of grants the model has issued, consumed when the DUT grants.
  logic [IW-1:0] exp_q[$];
  logic [N-1:0]  prev_gnt = '0;

  task automatic model_edge();
    bit got;
    int c;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_stall = 0; m_abort = 1'b0;
      m_idx = '0; m_tmo = '0; m_evt = 1'b0;
      exp_q.delete();
    end else begin
      m_tmo = '0;
      m_evt = 1'b0;
      if (m_owner < 0) begin
        got = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!got && cyc[c]) begin
            got = 1'b1;
            m_owner = c; m_idx = IW'(c); m_stall = 0; m_abort = 1'b0;
            exp_q.push_back(IW'(c));
          end
        end
      end else if (!cyc[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (!m_abort) begin
        if (stb[m_owner] && !ack && !err) begin
          m_stall++;
          if (TMO != 0 && m_stall == TMO) begin
            m_tmo   = N'(1) << m_owner;
            m_evt   = 1'b1;
            m_abort = 1'b1;
          end
        end else begin
          m_stall = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]  eg;
    logic [IW-1:0] e;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("gnt", gnt, eg);
    check("gnt_idx", gidx, m_idx);
    check("gnt_vld", gvld, (m_owner >= 0) && !m_abort);
    check("tmo", tmo, m_tmo);
    check("tmo_evt", evt, m_evt);
    if (prev_gnt == '0 && gnt != '0) begin
      check("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_grant_idx", gidx, e);
      end
    end
    prev_gnt = gnt;
  endtask

  // Driver: one clock, model follows the same edge, compare mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int idle, lat, z_tmo_cnt, z_own_cnt;
  bit seen;

  initial begin
    // Reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_state", 32'(st), 32'(ARB_IDLE));

    // All four requesting: grants rotate 0,1,2,3,0 with one idle cycle between.
    cyc = 4'hF;
    for (int g = 0; g < 5; g++) begin
      idle = 0;
      for (int t = 0; t < 10 && !gvld; t++) begin
        step();
        idle++;
      end
      check($sformatf("rr_vld%0d", g), gvld, 1);
      check($sformatf("rr_idx%0d", g), gidx, exp_order[g]);
      if (g > 0) check($sformatf("rr_gap%0d", g), idle, 1);
      stb = N'(1) << gidx; ack = 1'b1;
      step();
      ack = 1'b0; stb = '0;
      cyc[gidx] = 1'b0;
      step();
      cyc = 4'hF;
    end
    cyc = '0;

    // last=1 with masters 0 and 3 requesting: 3 wins, then 0.
    cyc = 4'b0010; step();
    cyc = 4'b0000; step();
    cyc = 4'b1001; step();
    check("wrap_gnt3", gnt, 4'b1000);
    cyc = 4'b0001; step(); step();
    check("wrap_gnt0", gnt, 4'b0001);
    cyc = '0; step();

    // Master 2 strobes into a silent slave: timeout after TMO cycles.
    cyc = 4'b0100; step();
    check("tmo_own2", gnt, 4'b0100);
    stb = 4'b0100; lat = 0; seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step();
      lat++;
      if (tmo != '0) seen = 1'b1;
    end
    check("tmo_seen", seen, 1);
    check("tmo_latency", lat, TMO);
    check("tmo_vec", tmo, 4'b0100);
    check("tmo_evt_pulse", evt, 1);
    step();
    check("tmo_one_cycle", tmo, 0);
    check("abort_masked", gvld, 0);
    check("abort_gnt_held", gnt, 4'b0100);
    check("abort_state", 32'(st), 32'(ARB_ABORT));
    ack = 1'b1; step(); ack = 1'b0;
    check("abort_late_ack", gvld, 0);

    // Reset while aborted with masters 1 and 2 requesting.
    cyc = 4'b0110; rst = 1'b1; step(); rst = 1'b0;
    check("rst_abort_gnt", gnt, 0);
    check("rst_abort_tmo", tmo, 0);
    check("rst_abort_state", 32'(st), 32'(ARB_IDLE));
    step();
    check("post_rst_gnt1", gnt, 4'b0010);
    check("post_rst_idx1", gidx, 1);
    stb = '0; cyc = '0; step();

    // ack arrives exactly as the stall count reaches TMO-1: no timeout.
    cyc = 4'b1000; step();
    stb = 4'b1000;
    repeat (TMO - 1) step();
    ack = 1'b1; step();
    check("ack_wins_tmo", tmo, 0);
    check("ack_wins_evt", evt, 0);
    check("ack_wins_state", 32'(st), 32'(ARB_OWNED));
    check("ack_wins_vld", gvld, 1);
    ack = 1'b0; stb = '0; cyc = '0; step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) cyc[b] = ~cyc[b];
        if ($urandom_range(0, 7) == 0) stb[b] = ~stb[b];
      end
      ack = ($urandom_range(0, 11) == 0);
      err = ($urandom_range(0, 23) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; ack = 1'b0; err = 1'b0; cyc = '0; stb = '0;

    // Watchdog disabled: long silent strobes never time out.
    z_stb = '1; z_tmo_cnt = 0; z_own_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) z_cyc[b] = ~z_cyc[b];
      step();
      if (z_tmo != '0 || z_evt) z_tmo_cnt++;
      if (z_vld) z_own_cnt++;
    end
    check("z_no_tmo", z_tmo_cnt, 0);
    check("z_owned", z_own_cnt > 100, 1);

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
